// File: rtl/fc_layer_sched_if.sv
// Handshake/data bundle between the FC-layer scheduler, its host and the
// per-neuron MAC local controller. The master modport is the scheduler side.
//   host:  start_i, abort_i -> ; busy_o, done_o, class_o, max_o, err_o <-
//   local controller: lc_start_o, neuron_o, w_base_o -> ; lc_wr_i, acc_i <-
interface fc_layer_sched_if #(
    parameter int ACC_W  = 20,
    parameter int NIDX_W = 4,
    parameter int WB_W   = 9
);
    logic              start_i;
    logic              abort_i;
    logic              lc_start_o;
    logic              lc_wr_i;
    logic [ACC_W-1:0]  acc_i;
    logic [NIDX_W-1:0] neuron_o;
    logic [WB_W-1:0]   w_base_o;
    logic              busy_o;
    logic              done_o;
    logic [NIDX_W-1:0] class_o;
    logic [ACC_W-1:0]  max_o;
    logic              err_o;

    modport master (
        input  start_i, abort_i, lc_wr_i, acc_i,
        output lc_start_o, neuron_o, w_base_o,
        output busy_o, done_o, class_o, max_o, err_o
    );

    modport slave (
        output start_i, abort_i, lc_wr_i, acc_i,
        input  lc_start_o, neuron_o, w_base_o,
        input  busy_o, done_o, class_o, max_o, err_o
    );
endinterface

// File: rtl/fc_layer_sched.sv
// Fully-connected layer scheduler: issues one local-controller start per
// output neuron, collects results, tracks the signed argmax and reports it.
// Ports: clk_i, rst_i (sync, active-high), bus (fc_layer_sched_if.master).
module fc_layer_sched #(
    parameter int NUM_OUT = 10,
    parameter int IN_LEN  = 32,
    parameter int ACC_W   = 20,
    parameter int NIDX_W  = 4,
    parameter int WB_W    = 9,
    parameter int TIMEOUT = 64
) (
    input logic               clk_i,
    input logic               rst_i,
    fc_layer_sched_if.master  bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [NIDX_W-1:0] LAST   = NIDX_W'(NUM_OUT - 1);
    localparam logic [WB_W-1:0]   STRIDE = WB_W'(IN_LEN);
    localparam logic [TW-1:0]     TLAST  = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_GAP, S_DONE, S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [NIDX_W-1:0] neuron_q, neuron_d;
    logic [WB_W-1:0]   w_base_q, w_base_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [ACC_W-1:0]  trk_max_q, trk_max_d;
    logic [NIDX_W-1:0] trk_cls_q, trk_cls_d;
    logic              trk_vld_q, trk_vld_d;
    logic [ACC_W-1:0]  max_out_q, max_out_d;
    logic [NIDX_W-1:0] cls_out_q, cls_out_d;
    logic              err_q, err_d;

    logic              go;
    logic              upd;
    logic [ACC_W-1:0]  cand_max;
    logic [NIDX_W-1:0] cand_cls;

    // Strict greater-than keeps the lower index on ties; an invalid
    // tracker always takes the first result regardless of its sign.
    always_comb begin
        upd      = !trk_vld_q ||
                   ($signed(bus.acc_i) > $signed(trk_max_q));
        cand_max = upd ? bus.acc_i : trk_max_q;
        cand_cls = upd ? neuron_q  : trk_cls_q;
    end

    always_comb begin
        state_d   = state_q;
        neuron_d  = neuron_q;
        w_base_d  = w_base_q;
        timer_d   = timer_q;
        trk_max_d = trk_max_q;
        trk_cls_d = trk_cls_q;
        trk_vld_d = trk_vld_q;
        max_out_d = max_out_q;
        cls_out_d = cls_out_q;
        err_d     = err_q;
        go        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    go = 1'b1;
                end
            end
            S_ISSUE: begin
                if (bus.abort_i) begin
                    state_d   = S_IDLE;
                    trk_vld_d = 1'b0;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                timer_d = timer_q + 1'b1;
                if (bus.abort_i) begin
                    state_d   = S_IDLE;
                    trk_vld_d = 1'b0;
                end else if (bus.lc_wr_i) begin
                    trk_max_d = cand_max;
                    trk_cls_d = cand_cls;
                    trk_vld_d = 1'b1;
                    if (neuron_q == LAST) begin
                        state_d   = S_DONE;
                        max_out_d = cand_max;
                        cls_out_d = cand_cls;
                    end else begin
                        state_d = S_GAP;
                    end
                end else if (timer_q == TLAST) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end
            end
            S_GAP: begin
                if (bus.abort_i) begin
                    state_d   = S_IDLE;
                    trk_vld_d = 1'b0;
                end else begin
                    state_d  = S_ISSUE;
                    neuron_d = neuron_q + 1'b1;
                    w_base_d = w_base_q + STRIDE;
                    timer_d  = '0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (bus.abort_i) begin
                    trk_vld_d = 1'b0;
                end
            end
            S_ERR: begin
                // err_o stays sticky through an abort
                if (bus.abort_i) begin
                    state_d = S_IDLE;
                end else if (bus.start_i) begin
                    go = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (go) begin
            state_d   = S_ISSUE;
            neuron_d  = '0;
            w_base_d  = '0;
            timer_d   = '0;
            err_d     = 1'b0;
            trk_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            neuron_q  <= '0;
            w_base_q  <= '0;
            timer_q   <= '0;
            trk_max_q <= '0;
            trk_cls_q <= '0;
            trk_vld_q <= 1'b0;
            max_out_q <= '0;
            cls_out_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            neuron_q  <= neuron_d;
            w_base_q  <= w_base_d;
            timer_q   <= timer_d;
            trk_max_q <= trk_max_d;
            trk_cls_q <= trk_cls_d;
            trk_vld_q <= trk_vld_d;
            max_out_q <= max_out_d;
            cls_out_q <= cls_out_d;
            err_q     <= err_d;
        end
    end

    assign bus.lc_start_o = (state_q == S_ISSUE);
    assign bus.busy_o     = (state_q != S_IDLE);
    assign bus.done_o     = (state_q == S_DONE);
    assign bus.neuron_o   = neuron_q;
    assign bus.w_base_o   = w_base_q;
    assign bus.class_o    = cls_out_q;
    assign bus.max_o      = max_out_q;
    assign bus.err_o      = err_q;
endmodule

// File: tb/tb_fc_layer_sched.sv
// Testbench for fc_layer_sched: table of full passes plus directed
// watchdog, abort, spurious-input and mid-pass reset sequences.
module tb_fc_layer_sched;
    localparam int NUM_OUT = 10;
    localparam int IN_LEN  = 32;
    localparam int ACC_W   = 20;
    localparam int NIDX_W  = 4;
    localparam int WB_W    = 9;
    localparam int TIMEOUT = 64;
    localparam int NV      = 5;

    typedef struct packed {
        logic [NUM_OUT-1:0][ACC_W-1:0] acc;
        logic [NIDX_W-1:0]             cls;
        logic [ACC_W-1:0]              mx;
        logic [7:0]                    dly;
        logic                          spur;
    } vec_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   ls_cnt = 0;

    fc_layer_sched_if #(
        .ACC_W(ACC_W), .NIDX_W(NIDX_W), .WB_W(WB_W)
    ) bus ();

    fc_layer_sched #(
        .NUM_OUT(NUM_OUT), .IN_LEN(IN_LEN), .ACC_W(ACC_W),
        .NIDX_W(NIDX_W), .WB_W(WB_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.done_o)     done_cnt <= done_cnt + 1;
        if (bus.lc_start_o) ls_cnt   <= ls_cnt + 1;
    end

    int va [NV][NUM_OUT] = '{
        '{5, -3, 17, 2, 17, 0, -8, 9, 1, 4},
        '{-100, -50, -7, -7, -200, -9, -8, -300, -7, -1000},
        '{3, 3, 3, 3, 3, 3, 3, 3, 3, 4},
        '{-1, -1, -1, -1, -1, -1, -1, -1, -1, -1},
        '{5, -3, 17, 2, 17, 0, -8, 9, 1, 4}
    };
    int vc [NV] = '{2, 2, 9, 0, 2};
    int vm [NV] = '{17, -7, 4, -1, 17};
    int vd [NV] = '{36, 1, 64, 2, 5};
    int vs [NV] = '{0, 0, 0, 0, 1};

    vec_t tbl [NV];

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_a"}, {bus.lc_start_o, bus.neuron_o, bus.w_base_o,
                         bus.busy_o, bus.done_o, bus.err_o}, 0);
        chk({nm, "_b"}, {bus.class_o, bus.max_o}, 0);
    endtask

    task automatic kick();
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
    endtask

    task automatic wait_issue(input int n);
        for (int k = 0; k < 8 && bus.lc_start_o !== 1'b1; k++) step();
        chk("issue", bus.lc_start_o, 1);
        chk("neuron", bus.neuron_o, n);
        chk("w_base", bus.w_base_o, n * IN_LEN);
    endtask

    // Answer one neuron d cycles after its lc_start_o; optionally inject a
    // start_i in WAIT and an lc_wr_i in the following GAP cycle.
    task automatic serve(input int n, input int d,
                         input logic [ACC_W-1:0] a, input bit spur);
        wait_issue(n);
        for (int k = 1; k <= d; k++) begin
            step();
            bus.start_i = spur && (k == 1);
            if (k == d) begin
                bus.lc_wr_i = 1'b1;
                bus.acc_i   = a;
            end
        end
        chk("wait_hold", {bus.lc_start_o, bus.neuron_o}, n);
        step();
        bus.lc_wr_i = 1'b0;
        bus.start_i = 1'b0;
        if (spur) begin
            chk("gap", {bus.lc_start_o, bus.busy_o}, 1);
            bus.lc_wr_i = 1'b1;
            bus.acc_i   = {1'b0, {(ACC_W-1){1'b1}}};
            step();
            bus.lc_wr_i = 1'b0;
        end
    endtask

    task automatic run_pass(input vec_t v, input string tag);
        int d0;
        int l0;
        kick();
        d0 = done_cnt;
        l0 = ls_cnt;
        for (int n = 0; n < NUM_OUT; n++)
            serve(n, int'(v.dly), v.acc[n],
                  v.spur && (n < NUM_OUT - 1));
        chk({tag, "_done"}, bus.done_o, 1);
        chk({tag, "_class"}, bus.class_o, v.cls);
        chk({tag, "_max"}, bus.max_o, v.mx);
        step();
        chk({tag, "_idle"}, {bus.done_o, bus.busy_o}, 0);
        chk({tag, "_ndone"}, done_cnt - d0, 1);
        chk({tag, "_nstart"}, ls_cnt - l0, NUM_OUT);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        int d0;
        for (int v = 0; v < NV; v++) begin
            for (int i = 0; i < NUM_OUT; i++)
                tbl[v].acc[i] = ACC_W'(va[v][i]);
            tbl[v].cls  = NIDX_W'(vc[v]);
            tbl[v].mx   = ACC_W'(vm[v]);
            tbl[v].dly  = 8'(vd[v]);
            tbl[v].spur = vs[v] != 0;
        end

        rst         = 1'b1;
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        bus.lc_wr_i = 1'b0;
        bus.acc_i   = '0;
        repeat (3) step();
        rst = 1'b0;
        chk_zero("reset");

        // lc_wr_i in IDLE must be ignored
        bus.lc_wr_i = 1'b1;
        bus.acc_i   = ACC_W'(99);
        step();
        bus.lc_wr_i = 1'b0;
        chk_zero("idle_wr");

        for (int v = 0; v < NV; v++)
            run_pass(tbl[v], $sformatf("vec%0d", v));

        // abort coincident with lc_wr_i of neuron 5
        kick();
        d0 = done_cnt;
        for (int n = 0; n < 5; n++) serve(n, 3, ACC_W'(1000), 1'b0);
        wait_issue(5);
        repeat (2) step();
        step();
        bus.lc_wr_i = 1'b1;
        bus.acc_i   = ACC_W'(2000);
        bus.abort_i = 1'b1;
        step();
        bus.lc_wr_i = 1'b0;
        bus.abort_i = 1'b0;
        chk("abort_idle", {bus.busy_o, bus.lc_start_o}, 0);
        repeat (3) step();
        chk("abort_ndone", done_cnt - d0, 0);
        chk("abort_class", bus.class_o, 2);
        chk("abort_max", bus.max_o, 17);

        // watchdog on neuron 3
        kick();
        d0 = done_cnt;
        for (int n = 0; n < 3; n++) serve(n, 2, '0, 1'b0);
        wait_issue(3);
        repeat (TIMEOUT) step();
        chk("wd_pre", {bus.err_o, bus.busy_o}, 1);
        step();
        chk("wd_err", {bus.err_o, bus.busy_o, bus.lc_start_o}, 3'b110);
        repeat (5) step();
        chk("wd_hold", {bus.err_o, bus.busy_o, bus.done_o}, 3'b110);
        chk("wd_ndone", done_cnt - d0, 0);
        kick();
        chk("wd_restart", {bus.err_o, bus.lc_start_o}, 1);
        chk("wd_neuron", {bus.neuron_o, bus.w_base_o}, 0);
        repeat (TIMEOUT + 1) step();
        chk("wd_err2", bus.err_o, 1);
        bus.abort_i = 1'b1;
        step();
        bus.abort_i = 1'b0;
        chk("wd_abort", {bus.err_o, bus.busy_o}, 2'b10);
        kick();
        chk("wd_clr", {bus.err_o, bus.lc_start_o}, 1);
        bus.abort_i = 1'b1;
        step();
        bus.abort_i = 1'b0;
        chk("wd_idle", bus.busy_o, 0);

        // reset while waiting on neuron 7
        kick();
        for (int n = 0; n < 7; n++) serve(n, 2, ACC_W'(50), 1'b0);
        wait_issue(7);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_zero("mid_rst");
        step();
        chk_zero("mid_rst2");
        run_pass(tbl[0], "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
